bcd_timekeeper: RTL and testbench

- Parametrised successor to the four-digit digital clock.
- Single clock domain. An internal prescaler replaces the separate 1 Hz clock input.
- Adds seconds digits, a runtime 12/24-hour mode with a PM flag, an hour-set button, a seconds-tick strobe, and synchronised, edge-detected set buttons.
- Drives the BCD display mux and the seven-segment driver.

---
 rtl/bcd_timekeeper_if.sv | 28 ++
 rtl/bcd_timekeeper.sv | 167 ++++++++++++++++
 tb/tb_bcd_timekeeper.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_timekeeper_if.sv
// bcd_timekeeper_if: set buttons and display mode in, BCD digits and status out.
// master drives the controls (board or bench); slave is the timekeeper.
interface bcd_timekeeper_if;
  logic       mode_24h;
  logic       minbtn;
  logic       tenminbtn;
  logic       hrbtn;
  logic [3:0] tenhrout;
  logic [3:0] onehrout;
  logic [3:0] tenminout;
  logic [3:0] oneminout;
  logic [3:0] tensecout;
  logic [3:0] onesecout;
  logic       pm;
  logic       sec_pulse;

  modport master (
    output mode_24h, minbtn, tenminbtn, hrbtn,
    input  tenhrout, onehrout, tenminout, oneminout,
    input  tensecout, onesecout, pm, sec_pulse
  );

  modport slave (
    input  mode_24h, minbtn, tenminbtn, hrbtn,
    output tenhrout, onehrout, tenminout, oneminout,
    output tensecout, onesecout, pm, sec_pulse
  );
endinterface

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: prescaled hh:mm:ss clock, 12/24h display, hour/min set buttons.
// Optional macro DEBOUNCE_EN adds a stable-count debouncer on each button.
module bcd_timekeeper #(
  parameter int CLK_DIV         = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic             clk100MHz,
  input logic             rst,
  bcd_timekeeper_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
  end

  // bit 0 = minute, bit 1 = ten-minute, bit 2 = hour
  logic [2:0] raw;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] lvl;
  logic [2:0] lvl_q;
  logic [2:0] armed;
  logic [2:0] press;
  logic [1:0] vld;

  assign raw = {bus.hrbtn, bus.tenminbtn, bus.minbtn};

  // armed blocks a button held through reset until it is seen released
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      vld   <= '0;
      armed <= '0;
      lvl_q <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      vld   <= {vld[0], 1'b1};
      armed <= armed | ({3{vld[1]}} & ~s2);
      lvl_q <= lvl;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [3];
  logic [2:0]    db;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = db;
`else
  assign lvl = s2;
`endif

  assign press = lvl & ~lvl_q & armed;

  logic [PW-1:0] presc;
  logic [3:0]    onesec;
  logic [3:0]    tensec;
  logic [3:0]    onemin;
  logic [3:0]    tenmin;
  logic [4:0]    hr;
  logic          pulse;
  logic          tick;
  logic          c0, c1, c2, c3;

  assign tick = presc == PMAX;
  assign c0   = onesec == 4'd9;
  assign c1   = c0 & (tensec == 4'd5);
  assign c2   = c1 & (onemin == 4'd9);
  assign c3   = c2 & (tenmin == 4'd5);

  // a press preempts a coinciding tick and restarts the second
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      onesec <= '0;
      tensec <= '0;
      onemin <= '0;
      tenmin <= '0;
      hr     <= '0;
      pulse  <= 1'b0;
    end else if (|press) begin
      presc  <= '0;
      pulse  <= 1'b0;
      onesec <= '0;
      tensec <= '0;
      if (press[0])
        onemin <= (onemin == 4'd9) ? 4'd0 : onemin + 4'd1;
      if (press[1])
        tenmin <= (tenmin == 4'd5) ? 4'd0 : tenmin + 4'd1;
      if (press[2])
        hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
    end else if (tick) begin
      presc  <= '0;
      pulse  <= 1'b1;
      onesec <= c0 ? 4'd0 : onesec + 4'd1;
      if (c0) tensec <= c1 ? 4'd0 : tensec + 4'd1;
      if (c1) onemin <= c2 ? 4'd0 : onemin + 4'd1;
      if (c2) tenmin <= c3 ? 4'd0 : tenmin + 4'd1;
      if (c3) hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
    end else begin
      presc <= presc + 1'b1;
      pulse <= 1'b0;
    end
  end

  logic [4:0] hdisp;
  logic [3:0] hten;
  logic [3:0] hone;

  always_comb begin
    hdisp = hr;
    if (!bus.mode_24h) begin
      unique case (1'b1)
        (hr == 5'd0): hdisp = 5'd12;
        (hr > 5'd12): hdisp = hr - 5'd12;
        default:      hdisp = hr;
      endcase
    end
    hten = 4'd0;
    hone = hdisp[3:0];
    unique case (1'b1)
      (hdisp >= 5'd20): begin
        hten = 4'd2;
        hone = 4'(hdisp - 5'd20);
      end
      (hdisp >= 5'd10 && hdisp < 5'd20): begin
        hten = 4'd1;
        hone = 4'(hdisp - 5'd10);
      end
      default: ;
    endcase
  end

  assign bus.tenhrout  = hten;
  assign bus.onehrout  = hone;
  assign bus.tenminout = tenmin;
  assign bus.oneminout = onemin;
  assign bus.tensecout = tensec;
  assign bus.onesecout = onesec;
  assign bus.pm        = hr >= 5'd12;
  assign bus.sec_pulse = pulse;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: random and directed stimulus against a time-of-day model.
// Model keeps time as seconds since midnight and button levels as edge history.
module tb_bcd_timekeeper;

  localparam int CLK_DIV = 4;
`ifdef DEBOUNCE_EN
  localparam int DB = 5;
`else
  localparam int DB = 0;
`endif
  localparam int L = 3 + DB;

  logic clk100MHz = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bcd_timekeeper_if bus();

  bcd_timekeeper #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_CYCLES(5)
  ) dut (
    .clk100MHz(clk100MHz),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk100MHz = ~clk100MHz;

  logic [23:0] dd;
  assign dd = {bus.tenhrout, bus.onehrout, bus.tenminout,
               bus.oneminout, bus.tensecout, bus.onesecout};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_disp(int t, logic m24);
    int h, mi, s, hd;
    h  = t / 3600;
    mi = (t / 60) % 60;
    s  = t % 60;
    hd = m24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    return {4'(hd / 10), 4'(hd % 10), 4'(mi / 10),
            4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // reference model: rq = raw samples, yq = synchronised, dq = accepted level
  int         mt;
  int         mpresc;
  bit         mpulse;
  logic [2:0] rq[$];
  logic [2:0] yq[$];
  logic [2:0] dq[$];
  logic [2:0] marm;

  initial begin
    forever begin
      @(posedge clk100MHz or posedge rst);
      if (rst) begin
        mt = 0; mpresc = 0; mpulse = 0; marm = '0;
        rq = {3'b000}; yq = {3'b000}; dq = {3'b000};
      end else begin
        int k, hh, mm;
        logic [2:0] pr, yk, dk;
        k  = dq.size();
        pr = dq[k-1] & ~((k >= 2) ? dq[k-2] : 3'b000) & marm;
        yk = rq[k-1];
        rq.push_back({bus.hrbtn, bus.tenminbtn, bus.minbtn});
        if (k >= 3) marm = marm | ~yq[k-1];
        dk = dq[k-1];
`ifdef DEBOUNCE_EN
        if (k >= DB) begin
          for (int b = 0; b < 3; b++) begin
            bit flip;
            flip = 1;
            for (int j = k - DB; j < k; j++)
              if (yq[j][b] == dq[k-1][b]) flip = 0;
            if (flip) dk[b] = ~dk[b];
          end
        end
`else
        dk = yk;
`endif
        yq.push_back(yk);
        dq.push_back(dk);
        if (|pr) begin
          hh = mt / 3600;
          mm = (mt / 60) % 60;
          if (pr[0]) mm = (mm / 10) * 10 + (mm % 10 + 1) % 10;
          if (pr[1]) mm = ((mm / 10 + 1) % 6) * 10 + mm % 10;
          if (pr[2]) hh = (hh + 1) % 24;
          mt = hh * 3600 + mm * 60;
          mpresc = 0;
          mpulse = 0;
        end else if (mpresc == CLK_DIV - 1) begin
          mt = (mt + 1) % 86400;
          mpresc = 0;
          mpulse = 1;
        end else begin
          mpresc++;
          mpulse = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk100MHz);
      #1;
      check("disp", dd, exp_disp(mt, bus.mode_24h));
      check("pm", bus.pm, mt >= 43200);
      check("sec_pulse", bus.sec_pulse, mpulse);
    end
  end

  task automatic set_btn(int b, logic v);
    case (b)
      0: bus.minbtn = v;
      1: bus.tenminbtn = v;
      default: bus.hrbtn = v;
    endcase
  endtask

  task automatic press(int b, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk100MHz);
      set_btn(b, 1'b1);
      repeat (DB + 2) @(negedge clk100MHz);
      set_btn(b, 1'b0);
      repeat (DB + 3) @(negedge clk100MHz);
    end
  endtask

  initial begin
    logic [23:0] e;
    int hh, r;
    rst = 1'b1;
    bus.mode_24h = 1'b1;
    bus.minbtn = 1'b0;
    bus.tenminbtn = 1'b0;
    bus.hrbtn = 1'b0;

    repeat (3) @(negedge clk100MHz);
    check("rst_digits", dd, 24'h000000);
    check("rst_pm", bus.pm, 1'b0);
    check("rst_pulse", bus.sec_pulse, 1'b0);
    bus.mode_24h = 1'b0;
    #1;
    check("rst_12h", dd, 24'h120000);
    bus.mode_24h = 1'b1;
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      @(posedge clk100MHz);
      #1;
      check("tick_pulse", bus.sec_pulse, (i % 4) == 0);
    end
    check("tick_8", dd, 24'h000002);

    press(2, 23);
    press(1, 5);
    press(0, 9);
    for (int i = 0; i < 400 && mt != 86398; i++) @(negedge clk100MHz);
    check("preload", dd, 24'h235958);
    @(negedge clk100MHz);
    for (int i = 0; i < 8 && !mpulse; i++) @(negedge clk100MHz);
    check("t235959", dd, 24'h235959);
    check("pm_23", bus.pm, 1'b1);
    @(negedge clk100MHz);
    for (int i = 0; i < 8 && !mpulse; i++) @(negedge clk100MHz);
    check("wrap", dd, 24'h000000);
    check("pm_wrap", bus.pm, 1'b0);

    bus.mode_24h = 1'b0;
    #1;
    check("h12_0", dd[23:16], 8'h12);
    check("pm_0", bus.pm, 1'b0);
    press(2, 12);
    check("h12_12", dd[23:16], 8'h12);
    check("pm_12", bus.pm, 1'b1);
    press(2, 1);
    check("h12_13", dd[23:16], 8'h01);
    check("pm_13", bus.pm, 1'b1);
    bus.mode_24h = 1'b1;

    press(0, 9);
    check("min9", dd[15:8], 8'h09);
    @(negedge clk100MHz);
    bus.minbtn = 1'b1;
    repeat (L) @(posedge clk100MHz);
    #1;
    check("hold_land", dd[15:0], 16'h0000);
    repeat (20 - L) @(negedge clk100MHz);
    bus.minbtn = 1'b0;
    repeat (DB + 3) @(negedge clk100MHz);
    check("hold_once", dd[15:8], 8'h00);

    press(2, 11);
    press(1, 5);
    press(0, 9);
    r = -1;
    for (int i = 0; i < 400; i++) begin
      r = (3599 - mt) * CLK_DIV + (CLK_DIV - mpresc);
      if (r == L) break;
      @(negedge clk100MHz);
    end
    bus.tenminbtn = 1'b1;
    repeat (L) @(posedge clk100MHz);
    #1;
    check("tie_disp", dd, 24'h000900);
    check("tie_pulse", bus.sec_pulse, 1'b0);
    @(negedge clk100MHz);
    bus.tenminbtn = 1'b0;
    repeat (DB + 3) @(negedge clk100MHz);

`ifdef DEBOUNCE_EN
    hh = mt / 3600;
    e = exp_disp(hh * 3600, 1'b1);
    bus.hrbtn = 1'b1;
    repeat (3) @(negedge clk100MHz);
    bus.hrbtn = 1'b0;
    repeat (DB + 6) @(negedge clk100MHz);
    check("glitch", dd[23:16], e[23:16]);
`endif

    hh = mt / 3600;
    e = exp_disp(hh * 3600, 1'b1);
    bus.hrbtn = 1'b1;
    repeat (L - 1) @(posedge clk100MHz);
    #1;
    check("lat_before", dd[23:16], e[23:16]);
    e = exp_disp(((hh + 1) % 24) * 3600, 1'b1);
    @(posedge clk100MHz);
    #1;
    check("lat_land", dd[23:16], e[23:16]);
    @(negedge clk100MHz);
    bus.hrbtn = 1'b0;
    repeat (DB + 3) @(negedge clk100MHz);

    bus.minbtn = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk100MHz);
    rst = 1'b0;
    repeat (DB + 10) @(negedge clk100MHz);
    check("held_rst", dd[15:8], 8'h00);
    bus.minbtn = 1'b0;
    repeat (DB + 3) @(negedge clk100MHz);
    press(0, 1);
    check("repress", dd[15:8], 8'h01);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk100MHz);
      if ($urandom_range(0, 63) == 0) bus.mode_24h = ~bus.mode_24h;
      if ($urandom_range(0, 7) == 0) bus.minbtn = ~bus.minbtn;
      if ($urandom_range(0, 7) == 0) bus.tenminbtn = ~bus.tenminbtn;
      if ($urandom_range(0, 7) == 0) bus.hrbtn = ~bus.hrbtn;
      if (c == 1500 || $urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        @(negedge clk100MHz);
        rst = 1'b0;
      end
    end
    bus.minbtn = 1'b0;
    bus.tenminbtn = 1'b0;
    bus.hrbtn = 1'b0;
    repeat (DB + 10) @(negedge clk100MHz);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
